// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder; the only arithmetic in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract of two WIDTH-bit operands, LSB first, one bit per clock.
// Results are registered on entry to DONE and held until the next completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic             cell_sum;
    logic             cell_carry;
    logic             accept;
    logic             last_bit;

    fa_cell u_fa_cell (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (carry),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    // DONE accepts a new request just like IDLE, giving back-to-back operation.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == RUN) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (cnt == CNT_LAST) state_nxt = DONE;
            DONE: state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:  busy = 1'b1;
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is a + ~b + 1: invert b at capture and force the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= sub ? ~b : b;
            sum_sh <= '0;
            carry  <= sub ? 1'b1 : cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= {cell_sum, sum_sh[WIDTH-1:1]};
            carry  <= cell_carry;
            cnt    <= last_bit ? '0 : cnt + CNT_W'(1);
        end
    end

    // On the MSB edge the carry flop holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last_bit) begin
            sum_r  <= {cell_sum, sum_sh[WIDTH-1:1]};
            cout_r <= cell_carry;
            ovf_r  <= carry ^ cell_carry;
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder at WIDTH=8.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int passed;
    int total;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[7];

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v,
                            input logic tcin, input logic tsub);
        a     = ta;
        b     = tb_v;
        cin   = tcin;
        sub   = tsub;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns with the bench sampling inside the done cycle (or after the bound expires).
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cnt++;
            tick();
            edges++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] es,
                                input logic eco, input logic eov);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(eco));
        check({tag, " ovf"}, 32'(ovf), 32'(eov));
    endtask

    initial begin
        int edges;
        int busy_cnt;
        logic saw_done;

        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        sub    = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sub: 1'b0, s: 8'h96, co: 1'b0, ov: 1'b1};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b1, sub: 1'b0, s: 8'h01, co: 1'b1, ov: 1'b0};
        vecs[2] = '{a: 8'h10, b: 8'h20, cin: 1'b1, sub: 1'b1, s: 8'hF0, co: 1'b0, ov: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h01, cin: 1'b0, sub: 1'b1, s: 8'h7F, co: 1'b1, ov: 1'b1};
        vecs[4] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sub: 1'b0, s: 8'h80, co: 1'b0, ov: 1'b1};
        vecs[5] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sub: 1'b1, s: 8'h00, co: 1'b1, ov: 1'b0};
        vecs[6] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sub: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b1};

        // Reset state
        tick();
        tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle after release busy", 32'(busy), 32'd0);
        check("idle after release done", 32'(done), 32'd0);

        // Table-driven operations with latency, busy length and hold-after-done
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            wait_done(edges, busy_cnt);
            check($sformatf("v%0d latency", i), 32'(edges), 32'd8);
            check($sformatf("v%0d busy_cycles", i), 32'(busy_cnt), 32'd8);
            check_result($sformatf("v%0d", i), vecs[i].s, vecs[i].co, vecs[i].ov);
            tick();
            check($sformatf("v%0d done_one_cycle", i), 32'(done), 32'd0);
            check($sformatf("v%0d sum_hold", i), 32'(sum), 32'(vecs[i].s));
        end

        // Back-to-back: start in the DONE cycle is accepted with no idle gap
        start_op(8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(edges, busy_cnt);
        check_result("b2b first", 8'h7F, 1'b1, 1'b1);
        start_op(8'h01, 8'h01, 1'b0, 1'b0);
        check("b2b accepted busy", 32'(busy), 32'd1);
        check("b2b held sum during run", 32'(sum), 32'h7F);
        wait_done(edges, busy_cnt);
        check("b2b latency", 32'(edges), 32'd8);
        check_result("b2b second", 8'h02, 1'b0, 1'b0);
        tick();

        // start pulses during RUN with other operands are ignored
        start_op(8'hA5, 8'h11, 1'b0, 1'b0);
        tick();
        tick();
        a     = 8'hFF;
        b     = 8'hFF;
        sub   = 1'b1;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check("run ignore busy", 32'(busy), 32'd1);
        wait_done(edges, busy_cnt);
        check("run ignore latency", 32'(edges), 32'd4);
        check_result("run ignore", 8'hB6, 1'b0, 1'b0);
        tick();
        check("run ignore no requeue", 32'(busy), 32'd0);

        // Reset asserted mid-cycle at bit 4 aborts with no done pulse
        start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        check("abort ovf", 32'(ovf), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("abort no done", 32'(saw_done), 32'd0);

        // Fresh operation after release
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        wait_done(edges, busy_cnt);
        check("fresh latency", 32'(edges), 32'd8);
        check_result("fresh", 8'h46, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
